// File: rtl/mdio_user_slave.sv
// mdio_user_slave: Clause 22 MDIO management slave serving a small 16-bit register file, oversampled on clk
module mdio_user_slave #(
  parameter logic [4:0]  PHY_ADDR = 5'h01,
  parameter int          NUM_REGS = 4,
  parameter logic [15:0] ID_VALUE = 16'h1234
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mdc,
  input  logic                     mdio_i,
  output logic                     mdio_o,
  output logic                     mdio_oe,
  output logic [16*NUM_REGS-1:0]   regs_flat,
  output logic                     reg_wr_pulse,
  output logic [4:0]               reg_wr_addr,
  output logic [15:0]              reg_wr_data
);
  typedef enum logic [3:0] {IDLE, START, OP, PHYAD, REGAD, TA, DATA_WR, DATA_RD, SKIP} state_t;
  state_t state_q, state_d;
  logic [1:0] mdc_sync_q, mdio_sync_q;
  logic mdc_prev_q;
  logic [5:0] pre_q, pre_d;
  logic [4:0] cnt_q, cnt_d, phy_q, phy_d, ra_q, ra_d, wa_q, wa_d, ra_nx;
  logic rd_q, rd_d, o_q, o_d, oe_q, oe_d, pulse_q, pulse_d;
  logic [15:0] sh_q, sh_d, wd_q, wd_d, rd_data, wr_val;
  logic [NUM_REGS-1:0][15:0] regs_q, regs_d;
  logic rise, fall, bit_in;
  assign rise = mdc_sync_q[1] & ~mdc_prev_q;
  assign fall = ~mdc_sync_q[1] & mdc_prev_q;
  assign bit_in = mdio_sync_q[1];
  assign ra_nx = {ra_q[3:0], bit_in};
  assign wr_val = {sh_q[14:0], bit_in};
  assign mdio_o = o_q;
  assign mdio_oe = oe_q;
  assign reg_wr_pulse = pulse_q;
  assign reg_wr_addr = wa_q;
  assign reg_wr_data = wd_q;
  assign regs_flat = regs_q;
  always_comb begin
    rd_data = 16'h0000;
    for (int i = 0; i < NUM_REGS; i++)
      if (ra_nx == 5'(i)) rd_data = regs_q[i];
  end
  always_comb begin
    state_d = state_q;
    pre_d   = 6'd0;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    phy_d   = phy_q;
    ra_d    = ra_q;
    sh_d    = sh_q;
    o_d     = o_q;
    oe_d    = oe_q;
    pulse_d = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
    regs_d  = regs_q;
    regs_d[0] = ID_VALUE;
    case (state_q)
      IDLE: begin
        pre_d = pre_q;
        if (rise) begin
          pre_d   = bit_in ? ((pre_q == 6'd63) ? pre_q : pre_q + 6'd1) : 6'd0;
          state_d = (!bit_in && pre_q >= 6'd32) ? START : IDLE;
        end
      end
      START: if (rise) begin
        state_d = bit_in ? OP : IDLE;
        cnt_d   = 5'd0;
      end
      OP: if (rise) begin
        cnt_d = (cnt_q == 5'd0) ? 5'd1 : 5'd0;
        if (cnt_q == 5'd0) rd_d = bit_in;
        else state_d = (rd_q != bit_in) ? PHYAD : IDLE;
      end
      PHYAD: if (rise) begin
        phy_d   = {phy_q[3:0], bit_in};
        cnt_d   = (cnt_q == 5'd4) ? 5'd0 : cnt_q + 5'd1;
        state_d = (cnt_q == 5'd4) ? REGAD : PHYAD;
      end
      REGAD: if (rise) begin
        ra_d  = ra_nx;
        cnt_d = (cnt_q == 5'd4) ? 5'd0 : cnt_q + 5'd1;
        if (cnt_q == 5'd4) begin
          state_d = (phy_q != PHY_ADDR) ? SKIP : TA;
          sh_d    = rd_data;
        end
      end
      TA: if (rd_q ? fall : rise) begin
        cnt_d = (cnt_q == 5'd1) ? 5'd0 : cnt_q + 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = rd_q ? DATA_RD : DATA_WR;
          oe_d    = rd_q;
          o_d     = ~rd_q;
        end
      end
      DATA_WR: if (rise) begin
        sh_d  = wr_val;
        cnt_d = (cnt_q == 5'd15) ? 5'd0 : cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          state_d = IDLE;
          for (int i = 1; i < NUM_REGS; i++)
            if (ra_q == 5'(i)) begin
              regs_d[i] = wr_val;
              pulse_d   = 1'b1;
              wa_d      = ra_q;
              wd_d      = wr_val;
            end
        end
      end
      DATA_RD: if (fall) begin
        if (cnt_q == 5'd16) begin
          oe_d    = 1'b0;
          o_d     = 1'b1;
          state_d = IDLE;
          cnt_d   = 5'd0;
        end else begin
          o_d   = sh_q[15];
          sh_d  = {sh_q[14:0], 1'b0};
          cnt_d = cnt_q + 5'd1;
        end
      end
      SKIP: if (rise) begin
        cnt_d   = (cnt_q == 5'd17) ? 5'd0 : cnt_q + 5'd1;
        state_d = (cnt_q == 5'd17) ? IDLE : SKIP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mdc_sync_q  <= 2'b00;
      mdio_sync_q <= 2'b11;
      mdc_prev_q  <= 1'b0;
      state_q     <= IDLE;
      pre_q       <= 6'd0;
      cnt_q       <= 5'd0;
      rd_q        <= 1'b0;
      phy_q       <= 5'd0;
      ra_q        <= 5'd0;
      sh_q        <= 16'h0000;
      o_q         <= 1'b1;
      oe_q        <= 1'b0;
      pulse_q     <= 1'b0;
      wa_q        <= 5'd0;
      wd_q        <= 16'h0000;
      regs_q      <= '0;
      regs_q[0]   <= ID_VALUE;
    end else begin
      mdc_sync_q  <= {mdc_sync_q[0], mdc};
      mdio_sync_q <= {mdio_sync_q[0], mdio_i};
      mdc_prev_q  <= mdc_sync_q[1];
      state_q     <= state_d;
      pre_q       <= pre_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      phy_q       <= phy_d;
      ra_q        <= ra_d;
      sh_q        <= sh_d;
      o_q         <= o_d;
      oe_q        <= oe_d;
      pulse_q     <= pulse_d;
      wa_q        <= wa_d;
      wd_q        <= wd_d;
      regs_q      <= regs_d;
    end
  end
endmodule

// File: tb/tb_mdio_user_slave.sv
// tb_mdio_user_slave: randomized MDIO master with scoreboard-checked writes and reads
module tb_mdio_user_slave;
  localparam int          HALF = 6;
  localparam int          NR   = 4;
  localparam logic [4:0]  PA   = 5'h01;
  localparam logic [15:0] IDV  = 16'h1234;
  logic clk = 1'b0, rst_n = 1'b0, mdc = 1'b1, m_out = 1'b1;
  logic mdio_i, mdio_o, mdio_oe, reg_wr_pulse;
  logic [4:0] reg_wr_addr;
  logic [15:0] reg_wr_data;
  logic [16*NR-1:0] regs_flat;
  int errors = 0, checks = 0, rcnt = 0;
  typedef struct {logic [15:0] data; bit aborted;} rd_t;
  rd_t rq[$];
  logic [20:0] wq[$];
  logic [15:0] mregs [NR];
  logic [16:0] rbuf = '0;
  assign mdio_i = mdio_oe ? mdio_o : m_out;
  mdio_user_slave #(.PHY_ADDR(PA), .NUM_REGS(NR), .ID_VALUE(IDV)) dut (
    .clk(clk), .rst_n(rst_n), .mdc(mdc), .mdio_i(mdio_i), .mdio_o(mdio_o), .mdio_oe(mdio_oe),
    .regs_flat(regs_flat), .reg_wr_pulse(reg_wr_pulse), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (reg_wr_pulse === 1'b1) begin
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: addr %h data %h with no write expected", reg_wr_addr, reg_wr_data);
      end else begin
        logic [20:0] e;
        e = wq.pop_front();
        chk("wr_addr", 64'(reg_wr_addr), 64'(e[20:16]));
        chk("wr_data", 64'(reg_wr_data), 64'(e[15:0]));
        chk("wr_regs_flat", 64'(regs_flat[16*e[20:16] +: 16]), 64'(e[15:0]));
      end
    end
  end
  always @(posedge mdc) begin
    if (mdio_oe === 1'b1) begin
      rbuf = {rbuf[15:0], mdio_o};
      rcnt++;
    end else if (rcnt > 0) begin
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_drive: %0d bits driven, expected none", rcnt);
      end else begin
        rd_t e;
        e = rq.pop_front();
        if (e.aborted) begin
          checks++;
          if (rcnt >= 17) begin
            errors++;
            $display("FAIL abort_len: got %0d driven bits expected fewer than 17", rcnt);
          end
        end else begin
          chk("rd_len", 64'(rcnt), 64'd17);
          chk("rd_ta2", 64'(rbuf[16]), 64'd0);
          chk("rd_data", 64'(rbuf[15:0]), 64'(e.data));
        end
      end
      rcnt = 0;
    end
  end
  task automatic send_bit(input logic b, input bit do_rst);
    mdc = 1'b0;
    m_out = b;
    if (do_rst) begin
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_oe", 64'(mdio_oe), 64'd0);
      chk("rst_o", 64'(mdio_o), 64'd1);
      chk("rst_reg1", 64'(regs_flat[31:16]), 64'd0);
      for (int i = 1; i < NR; i++) mregs[i] = 16'h0000;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
    end else repeat (HALF) @(negedge clk);
    mdc = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask
  task automatic frame(input int pre, input logic [1:0] op, input logic [4:0] phy, input logic [4:0] ra,
                       input logic [15:0] data, input int rst_at);
    logic [31:0] f;
    bit rd, hit;
    f = {2'b01, op, phy, ra, 2'b10, data};
    rd = (op == 2'b10);
    hit = (pre >= 32) && (phy == PA) && (op == 2'b10 || op == 2'b01);
    if (hit && rd) begin
      rd_t e;
      e.data = (ra == 5'd0) ? IDV : (ra < NR) ? mregs[ra] : 16'h0000;
      e.aborted = (rst_at >= 0);
      rq.push_back(e);
    end
    if (hit && !rd && ra != 5'd0 && ra < NR) begin
      mregs[ra] = data;
      wq.push_back({ra, data});
    end
    repeat (pre) send_bit(1'b1, 1'b0);
    for (int i = 31; i >= 0; i--)
      send_bit((rd && i < 18) ? 1'b1 : f[i], hit && rd && i == rst_at);
  endtask
  task automatic check_regs(input string name);
    logic [16*NR-1:0] e;
    for (int i = 0; i < NR; i++) e[16*i +: 16] = (i == 0) ? IDV : mregs[i];
    chk(name, 64'(regs_flat), 64'(e));
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    for (int i = 0; i < NR; i++) mregs[i] = 16'h0000;
    repeat (3) @(negedge clk);
    chk("reset_o", 64'(mdio_o), 64'd1);
    chk("reset_oe", 64'(mdio_oe), 64'd0);
    chk("reset_pulse", 64'(reg_wr_pulse), 64'd0);
    chk("reset_wr_addr", 64'(reg_wr_addr), 64'd0);
    chk("reset_wr_data", 64'(reg_wr_data), 64'd0);
    check_regs("reset_regs");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    frame(32, 2'b01, 5'h01, 5'h01, 16'hAAAA, -1);
    check_regs("regs_after_write1");
    frame(32, 2'b10, 5'h01, 5'h01, 16'h0000, -1);
    frame(32, 2'b10, 5'h01, 5'h00, 16'h0000, -1);
    frame(32, 2'b01, 5'h01, 5'h00, 16'h5555, -1);
    frame(32, 2'b10, 5'h01, 5'h00, 16'h0000, -1);
    frame(32, 2'b01, 5'h08, 5'h10, 16'h0140, -1);
    frame(32, 2'b10, 5'h08, 5'h10, 16'h0000, -1);
    check_regs("regs_after_foreign_phy");
    frame(32, 2'b10, 5'h01, 5'h01, 16'h0000, -1);
    send_bit(1'b0, 1'b0);
    frame(31, 2'b01, 5'h01, 5'h02, 16'h1357, -1);
    check_regs("regs_after_short_preamble");
    frame(32, 2'b11, 5'h01, 5'h01, 16'h2468, -1);
    check_regs("regs_after_bad_opcode");
    frame(32, 2'b01, 5'h01, 5'h02, 16'h0F0F, -1);
    frame(32, 2'b10, 5'h01, 5'h1F, 16'h0000, -1);
    frame(32, 2'b01, 5'h01, 5'h1F, 16'hBEEF, -1);
    check_regs("regs_after_out_of_range");
    frame(32, 2'b10, 5'h01, 5'h01, 16'h0000, 8);
    check_regs("regs_after_reset");
    frame(32, 2'b01, 5'h01, 5'h03, 16'hC3C3, -1);
    frame(32, 2'b10, 5'h01, 5'h03, 16'h0000, -1);
    for (int n = 0; n < 30; n++) begin
      logic [1:0] op;
      logic [4:0] phy, ra;
      op  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01);
      phy = ($urandom_range(0, 3) == 0) ? 5'($urandom) : PA;
      ra  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, NR - 1));
      frame(32 + int'($urandom_range(0, 4)), op, phy, ra, 16'($urandom), -1);
      check_regs("regs_random");
    end
    repeat (4) send_bit(1'b1, 1'b0);
    chk("write_queue_drained", 64'(wq.size()), 64'd0);
    chk("read_queue_drained", 64'(rq.size()), 64'd0);
    chk("bus_released", 64'(mdio_oe), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mdio_user_slave.md
# mdio_user_slave

MDIO (IEEE 802.3 Clause 22) management slave that answers the MDIO master on the shared MDC/MDIO bus at a configurable PHY address. It sits downstream of the MDIO master alongside the GMII-to-RGMII core. It owns a small 16-bit register file and serves master reads and writes to it. MDC and MDIO are oversampled in the system clock domain, so the block needs no second clock.

## Interface

- PHY_ADDR, 5'h01, PHY address this slave responds to
- NUM_REGS, 4, number of 16-bit registers; legal range 2..32
- ID_VALUE, 16'h1234, constant returned by read-only register 0

- clk  in  1  system clock; samples MDC and MDIO
- rst_n  in  1  reset; one clock domain, synchronous, active-low
- mdc  in  1  MDIO management clock from the master
- mdio_i  in  1  bus data input from the tri-state pad
- mdio_o  out  1  bus data output to the pad
- mdio_oe  out  1  pad output enable; 1 = slave drives the bus
- regs_flat  out  16*NUM_REGS  register contents; reg n is at bits [16n+15:16n]
- reg_wr_pulse  out  1  one-cycle strobe on every accepted write
- reg_wr_addr  out  5  register address of the last accepted write
- reg_wr_data  out  16  data of the last accepted write

## Operation

- mdc and mdio_i each pass through a 2-flop synchronizer. Edge detect works on the synced mdc.
- On an mdc rising edge the slave samples synced mdio. On an mdc falling edge it updates mdio_o/mdio_oe.
- FSM states: IDLE, START, OP, PHYAD, REGAD, TA, DATA_WR, DATA_RD, SKIP.
- IDLE: a saturating 6-bit counter counts consecutive 1s.
  - A 0 sampled when the count is ≥32 → START.
  - A 0 sampled when the count is <32 → clear the counter and stay in IDLE.
- START: expect 1 → OP; if 0 → IDLE.
- OP: 2 bits. 10 = read, 01 = write. 00 or 11 → IDLE.
- PHYAD: 5 bits, MSB first.
- REGAD: 5 bits, MSB first. After the last REGAD bit:
  - PHY address mismatch → SKIP for the remaining 18 bits, then IDLE. The slave never drives the bus and never writes.
  - Match and read → the shift register loads a snapshot of the addressed register, then TA.
  - Match and write → TA.
- Read data source: ID_VALUE for reg 0, the register for reg 1..NUM_REGS-1, 16'h0000 for out-of-range addresses.
- TA on a read:
  - 1st falling edge after the last REGAD bit: mdio_oe stays 0.
  - 2nd falling edge: mdio_oe=1, mdio_o=0.
  - Next 16 falling edges: drive data MSB first (DATA_RD).
  - Falling edge after bit 0: mdio_oe=0, mdio_o=1, → IDLE.
- TA on a write: both TA bits are sampled and ignored (not checked), then DATA_WR.
- DATA_WR: 16 bits shifted in MSB first. At the 16th rising edge:
  - Register 1..NUM_REGS-1: the register updates, reg_wr_pulse=1 for one clk, and reg_wr_addr/reg_wr_data update.
  - Register 0 or out-of-range: the write is discarded and no pulse is generated.
- Every return to IDLE clears the preamble counter, so each frame needs its own ≥32-bit preamble.
- Reset values:
  - mdio_o=1, mdio_oe=0, reg_wr_pulse=0, reg_wr_addr=0, reg_wr_data=0.
  - Registers 1..N-1 = 0; regs_flat reg 0 = ID_VALUE.
  - State IDLE, counter 0.
- Reset mid-frame: the bus is released at the next clk edge and the partial frame is discarded.

## Timing

- Sample and drive actions occur 3 clk cycles after the mdc edge: 2 cycles of synchronizer plus 1 of edge registration.
- Requirement: mdc high and low phases each ≥6 clk cycles, so drive latency stays below half an MDC period.
- reg_wr_pulse and the register update occur on the same clk edge, 3 clk after the 16th DATA_WR rising mdc edge.
- regs_flat follows the register update with no extra latency.
- mdio_oe is never 1 outside a matched read's TA2 + DATA_RD window.
- Glitches on mdc shorter than 2 clk cycles are not guaranteed to be filtered. The master guarantees clean MDC.

## Test plan

- Write PHY 0x01, reg 0x01, 16'hAAAA (32-bit preamble) → reg_wr_pulse once, reg_wr_addr=1, reg_wr_data=16'hAAAA, regs_flat[31:16]=16'hAAAA. Reading reg 0x01 back → master data_out=16'hAAAA.
- Read PHY 0x01, reg 0x00 → mdio_oe asserted for exactly 17 MDC bits (TA2 + 16 data), data 16'h1234. Write 16'h5555 to reg 0x00 → no pulse; a re-read still returns 16'h1234.
- Frames to PHY 0x08 (write 16'h0140 to reg 0x10, then read reg 0x10) → mdio_oe stays 0 throughout, no pulse, regs_flat unchanged. A following read of PHY 0x01 reg 0x01 is served correctly.
- Preamble of 31 ones followed by a valid write frame → ignored, no pulse. Opcode 2'b11 after a full preamble → ignored and the FSM returns to IDLE.
- Read of reg 0x1F (out of range) → data 16'h0000. Write of 16'hBEEF to reg 0x1F → no pulse.
- rst_n=0 for 1 clk during DATA_RD bit 8 → mdio_oe=0 and mdio_o=1 at the next edge, reg 1 returns to 0. The next full frame is served normally.
